// File: rtl/univ_reg.sv
// univ_reg: WIDTH-bit edge-triggered universal register with a gate-style enable.
// Modes: hold, load, shift left/right, rotate left/right, count up/down.
// Also provides a complemented output, serial taps and a one-cycle registered wrap flag.
module univ_reg #(
   parameter int unsigned WIDTH     = 8,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             sout_l,
   output logic             sout_r,
   output logic             wrap
);

   typedef enum logic [2:0] {
      ModeHold = 3'b000,
      ModeLoad = 3'b001,
      ModeShl  = 3'b010,
      ModeShr  = 3'b011,
      ModeRol  = 3'b100,
      ModeRor  = 3'b101,
      ModeInc  = 3'b110,
      ModeDec  = 3'b111
   } mode_e;

   localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZEROS = {WIDTH{1'b0}};

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;

   // Next-state decode; wrap defaults low so it can never be sticky.
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (en) begin
         unique case (mode_e'(mode))
            ModeHold: q_d = q_q;
            ModeLoad: q_d = d;
            ModeShl:  q_d = {q_q[WIDTH-2:0], sin_r};
            ModeShr:  q_d = {sin_l, q_q[WIDTH-1:1]};
            ModeRol:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            ModeRor:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            ModeInc: begin
               q_d    = q_q + ONE;
               wrap_d = (q_q == ONES);
            end
            ModeDec: begin
               q_d    = q_q - ONE;
               wrap_d = (q_q == ZEROS);
            end
            default: q_d = q_q;
         endcase
      end
   end

   // State register; synchronous reset overrides any mode, including a wrap edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= RESET_VAL[WIDTH-1:0];
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   // Outputs derive from registered state only.
   always_comb begin
      q      = q_q;
      qn     = ~q_q;
      sout_l = q_q[WIDTH-1];
      sout_r = q_q[0];
      wrap   = wrap_q;
   end

endmodule
